prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the processor core in reset (core_hold) until a complete, valid program is loaded.

Parameters:
ADDR_W, 8, instruction memory word-address width (256 words)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; transfer occurs when in_valid & in_ready at a rising edge
restart  input  1  single-cycle pulse; re-arms the loader
im_w_en  output  1  instruction memory write strobe, one cycle per word
im_w_addr  output  ADDR_W  instruction memory word address
im_w_data  output  32  instruction word
core_hold  output  1  1 = keep core in reset; drives the core's rst
load_done  output  1  program loaded successfully (level)
load_err  output  1  frame error (level)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low; all state clears immediately on rst=0.
- Reset values: state=IDLE, in_ready=1, im_w_en=0, im_w_addr=0, im_w_data=0, core_hold=1, load_done=0, load_err=0, word counter=0, byte lane=0, checksum accumulator=0.
- Frame format: SYNC_BYTE, then count byte N (word count, 0 encodes 256), then N*4 payload bytes, MSB first per word, then checksum byte (XOR of all payload bytes; see optional feature).
- IDLE: in_ready=1. Accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE -> LEN.
- LEN: the accepted byte latches N into a 9-bit word count. Clears the lane, word counter and checksum. -> DATA.
- DATA, byte accept:
  - Shift the byte into the assembly register: lane 0 -> [31:24], lane 3 -> [7:0].
  - XOR the byte into the checksum.
  - Lane increments mod 4.
- DATA, word write:
  - On the 4th byte of a word, im_w_en=1 on the next cycle, with im_w_data = the assembled word and im_w_addr = word counter.
  - The word counter increments after the write.
  - Write latency is one cycle after the last byte accept; im_w_en is never asserted two cycles back to back for the same address.
- DATA exit: after word N is written -> CSUM.
- CSUM: the accepted byte is compared with the accumulator. Match -> DONE; mismatch -> ERR.
- DONE: in_ready=0, load_done=1, core_hold=0. Stays in DONE until restart or reset.
- ERR: in_ready=0, load_err=1, core_hold=1. Stays in ERR until restart or reset.
- restart: from any state, on the next edge:
  - go to IDLE and clear load_done and load_err; core_hold=1;
  - a byte presented in the same cycle is discarded;
  - a pending im_w_en is cancelled.
- Address wrap: the word counter is ADDR_W bits wide. N=256 with ADDR_W=8 writes addresses 0..255 and ends with the counter wrapped to 0; completion is judged by the 9-bit count, never by the counter value.
- Stalls: in_valid low mid-word holds the lane, partial word and checksum indefinitely. There is no timeout.
- Reset mid-load:
  - Abort immediately; outputs return to their reset values.
  - Instruction memory contents already written are not erased.
  - core_hold=1 throughout.
- in_ready is combinational from state only, never from in_valid.

Optional Feature:
- Macro: PL_CSUM_EN
- Defined: the CSUM state exists; the checksum byte is required and a mismatch goes to ERR.
- Undefined:
  - No checksum byte is expected; the write of word N goes directly to DONE.
  - The checksum logic is absent and load_err is tied to 0.

Test Plan:
- Basic load: A5, 02, 24 08 00 05, 00 00 00 20, csum 0x09 -> writes addr0=0x24080005 and addr1=0x00000020, then load_done=1, core_hold=0 (checksum byte sent only when PL_CSUM_EN is defined).
- Bad checksum (PL_CSUM_EN): the same frame with csum 0x00 -> both words written, then load_err=1, core_hold=1, in_ready=0.
- Sync hunt and stalls: bytes 11, 22 before A5, and in_valid toggled low for 3 cycles between payload bytes -> junk bytes ignored, words assembled correctly, exactly 2 write strobes.
- Full depth: N=00, 1024 payload bytes, word i = i -> 256 writes to addresses 0..255, then DONE, im_w_addr wrapped to 0.
- Reset mid-load: rst=0 after 6 payload bytes -> im_w_en=0 immediately, state IDLE, core_hold=1. A subsequent full frame loads correctly from addr 0.
- Restart: a restart pulse in DONE -> IDLE, load_done=0, core_hold=1, in_ready=1. A byte presented in the restart cycle is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> big-endian 32-bit words into instruction memory.
// Optional checksum byte and error state enabled by defining PL_CSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_w_en,
  output logic [ADDR_W-1:0] im_w_addr,
  output logic [31:0]       im_w_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    StIdle, StLen, StData, StLast, StCsum, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic [8:0]        num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wen_q, wen_d;
`ifdef PL_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic              accept;

  assign in_ready  = (state_q == StIdle) || (state_q == StLen) ||
                     (state_q == StData) || (state_q == StCsum);
  assign accept    = in_valid && in_ready;
  assign load_done = (state_q == StDone);
  assign core_hold = !load_done;
`ifdef PL_CSUM_EN
  assign load_err  = (state_q == StErr);
`else
  assign load_err  = 1'b0;
`endif
  assign im_w_en   = wen_q;
  assign im_w_addr = addr_q;
  assign im_w_data = wdata_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    wcnt_d  = wcnt_q;
    num_d   = num_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
`ifdef PL_CSUM_EN
    csum_d  = csum_q;
`endif
    // The word address advances once the write strobe has been presented.
    if (wen_q) addr_d = addr_q + ADDR_W'(1);

    if (restart) begin
      state_d = StIdle;
      lane_d  = 2'd0;
      wcnt_d  = 9'd0;
      addr_d  = '0;
`ifdef PL_CSUM_EN
      csum_d  = 8'd0;
`endif
    end else begin
      case (state_q)
        StIdle: if (accept && in_data == SYNC_BYTE) state_d = StLen;
        StLen: begin
          if (accept) begin
            num_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            lane_d  = 2'd0;
            wcnt_d  = 9'd0;
            addr_d  = '0;
`ifdef PL_CSUM_EN
            csum_d  = 8'd0;
`endif
            state_d = StData;
          end
        end
        StData: begin
          if (accept) begin
`ifdef PL_CSUM_EN
            csum_d = csum_q ^ in_data;
`endif
            lane_d = lane_q + 2'd1;
            asm_d  = {asm_q[15:0], in_data};
            if (lane_q == 2'd3) begin
              wdata_d = {asm_q, in_data};
              wen_d   = 1'b1;
              wcnt_d  = wcnt_q + 9'd1;
              // Completion is judged by the 9-bit count so N=256 works with a wrapping address.
              if (wcnt_q + 9'd1 == num_q) state_d = StLast;
            end
          end
        end
        // Stall input while the final word is written so the next byte cannot be taken as data.
`ifdef PL_CSUM_EN
        StLast: state_d = StCsum;
        StCsum: if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
`else
        StLast: state_d = StDone;
`endif
        StDone, StErr: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lane_q  <= 2'd0;
      wcnt_q  <= 9'd0;
      num_q   <= 9'd0;
      addr_q  <= '0;
      asm_q   <= 24'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
`ifdef PL_CSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      wcnt_q  <= wcnt_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
`ifdef PL_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: cycle-level vector table plus multi-cycle frame sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        im_w_en;
  logic [7:0]  im_w_addr;
  logic [31:0] im_w_data;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .restart   (restart),
    .im_w_en   (im_w_en),
    .im_w_addr (im_w_addr),
    .im_w_data (im_w_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // ctl = {in_ready, im_w_en, load_done, core_hold, load_err}
  localparam logic [4:0] C_IDLE  = 5'b10010;
  localparam logic [4:0] C_WR    = 5'b11010;
  localparam logic [4:0] C_LASTW = 5'b01010;
  localparam logic [4:0] C_DONE  = 5'b00100;
  localparam logic [4:0] C_ERR   = 5'b00011;

  typedef struct {
    logic        rs;
    logic        v;
    logic [7:0]  d;
    logic [4:0]  ctl;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  bq[$];
  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Instruction-memory model fed by the write port.
  always @(negedge clk) begin
    if (im_w_en === 1'b1) begin
      mem[im_w_addr] = im_w_data;
      wr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic v, input logic [7:0] d, input logic [4:0] ctl,
                     input logic [7:0] a, input logic [31:0] dt);
    vecs.push_back('{rs, v, d, ctl, a, dt});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte timeout: got in_ready=0 expected 1 for byte %h", b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_queue();
    foreach (bq[i]) send_byte(bq[i]);
    bq.delete();
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(load_done || load_err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] ctl_now();
    return {in_ready, im_w_en, load_done, core_hold, load_err};
  endfunction

  initial begin
    int bad;
    logic [7:0] xa;
    xa = 8'hxx;
    // Basic frame with junk before sync and a three-cycle stall inside word 0.
    add(0, 1, 8'h11, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h22, C_IDLE, 8'h00, 0);
    add(0, 1, 8'hA5, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h02, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h24, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h08, C_IDLE, 8'h00, 0);
    add(0, 0, 8'h00, C_IDLE, 8'h00, 0);
    add(0, 0, 8'h00, C_IDLE, 8'h00, 0);
    add(0, 0, 8'h00, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h00, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h05, C_IDLE, 8'h00, 0);
    add(0, 1, 8'h00, C_WR,   8'h00, 32'h24080005);
    add(0, 1, 8'h00, C_IDLE, 8'h01, 0);
    add(0, 1, 8'h00, C_IDLE, 8'h01, 0);
    add(0, 1, 8'h20, C_IDLE, 8'h01, 0);
`ifdef PL_CSUM_EN
    add(0, 1, 8'h09, C_LASTW, 8'h01, 32'h00000020);
    add(0, 1, 8'h09, C_IDLE,  8'h02, 0);
`else
    add(0, 0, 8'h00, C_LASTW, 8'h01, 32'h00000020);
    add(0, 0, 8'h00, C_DONE,  8'h02, 0);
`endif
    add(0, 0, 8'h00, C_DONE, 8'h02, 0);
    // Restart in DONE, then restart in IDLE with a sync byte that must be dropped.
    add(1, 1, 8'hA5, C_DONE, 8'h02, 0);
    add(1, 1, 8'hA5, C_IDLE, xa, 0);
    add(0, 1, 8'h01, C_IDLE, xa, 0);
    add(0, 1, 8'hA5, C_IDLE, xa, 0);
    add(0, 1, 8'h01, C_IDLE, xa, 0);
    add(0, 1, 8'hDE, C_IDLE, 8'h00, 0);
    add(0, 1, 8'hAD, C_IDLE, 8'h00, 0);
    add(0, 1, 8'hBE, C_IDLE, 8'h00, 0);
    add(0, 1, 8'hEF, C_IDLE, 8'h00, 0);
`ifdef PL_CSUM_EN
    add(0, 1, 8'h22, C_LASTW, 8'h00, 32'hDEADBEEF);
    add(0, 1, 8'h22, C_IDLE,  8'h01, 0);
`else
    add(0, 0, 8'h00, C_LASTW, 8'h00, 32'hDEADBEEF);
    add(0, 0, 8'h00, C_DONE,  8'h01, 0);
`endif
    add(0, 0, 8'h00, C_DONE, 8'h01, 0);

    #1;
    check("reset ctl", 32'(ctl_now()), 32'(C_IDLE));
    check("reset addr", 32'(im_w_addr), 32'h0);
    check("reset data", im_w_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      restart  = vecs[i].rs;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      #1;
      check($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      if (!$isunknown(vecs[i].addr))
        check($sformatf("vec%0d addr", i), 32'(im_w_addr), 32'(vecs[i].addr));
      if (vecs[i].ctl[3])
        check($sformatf("vec%0d data", i), im_w_data, vecs[i].data);
    end
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;

`ifdef PL_CSUM_EN
    // Bad checksum: words still land, then error with core held.
    pulse_restart();
    wr_cnt = 0;
    bq = '{8'hA5, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
    send_queue();
    wait_end();
    check("badcsum ctl", 32'(ctl_now()), 32'(C_ERR));
    check("badcsum writes", wr_cnt, 2);
    check("badcsum mem0", mem[0], 32'h24080005);
    check("badcsum mem1", mem[1], 32'h00000020);
`endif

    // Full depth: N=0 means 256 words, address wraps back to 0.
    pulse_restart();
    wr_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFFFFFF;
    bq = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) begin
      bq.push_back(8'h00);
      bq.push_back(8'h00);
      bq.push_back(8'h00);
      bq.push_back(8'(i));
    end
`ifdef PL_CSUM_EN
    bq.push_back(8'h00);
`endif
    send_queue();
    wait_end();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'(i)) bad++;
    check("full writes", wr_cnt, 256);
    check("full contents bad", bad, 0);
    check("full ctl", 32'(ctl_now()), 32'(C_DONE));
    check("full addr wrap", 32'(im_w_addr), 32'h0);

    // Reset mid-load after six payload bytes, then a clean reload.
    pulse_restart();
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_queue();
    #2 rst = 1'b0;
    #1;
    check("midrst ctl", 32'(ctl_now()), 32'(C_IDLE));
    check("midrst addr", 32'(im_w_addr), 32'h0);
    check("midrst data", im_w_data, 32'h0);
    @(negedge clk);
    check("midrst hold", 32'(core_hold), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    wr_cnt = 0;
    bq = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef PL_CSUM_EN
    bq.push_back(8'h44);
`endif
    send_queue();
    wait_end();
    check("reload writes", wr_cnt, 2);
    check("reload mem0", mem[0], 32'hAABBCCDD);
    check("reload mem1", mem[1], 32'h11223344);
    check("reload ctl", 32'(ctl_now()), 32'(C_DONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
